// File: rtl/cpu_run_pkg.sv
// Shared types and constants for the CPU run sequencer: FSM state encoding and seven-segment codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RST     = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } run_state_t;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_ZERO = 7'h40;

  // Entry n is the pattern for hex digit n (entry 15 listed first)
  localparam logic [15:0][6:0] HEX_SEG_TBL = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG_TBL[nib];
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Hex digit to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Latency: combinational.
// Backpressure: none.
module hex7seg
  import cpu_run_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nib);

endmodule

// File: rtl/cpu_run_sequencer.sv
// Start-switch debounce, CPU reset window, run watch (halt write / cycle budget), result latch.
// Latency: launch to cpu_reset low RST_CYCLES+1 clocks; halt write to done 1 clock; all outputs registered.
// Backpressure: none; CPU is stalled via cpu_rdy outside RUN. Optional decoders: CPU_RUN_SEG_DECODE_EN.
module cpu_run_sequencer
  import cpu_run_pkg::*;
#(
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          RST_CYCLES      = 8,
  parameter logic [15:0] HALT_ADDR       = 16'hFFF0,
  parameter logic [31:0] MAX_CYCLES      = 32'd100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] cpu_ab,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_do,
  output logic        cpu_reset,
  output logic        cpu_rdy,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] disp_val,
  output logic [6:0]  seg0,
  output logic [6:0]  seg1,
  output logic [6:0]  seg2,
  output logic [6:0]  seg3,
  output logic [6:0]  seg4,
  output logic [6:0]  seg5,
  output logic [6:0]  seg6,
  output logic [6:0]  seg7
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RST_W-1:0] RST_CNT_LOAD = RST_W'(RST_CYCLES - 1);
  localparam logic [31:0]      TIMEOUT_AT   = MAX_CYCLES - 32'd1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   start_s;
  logic                   start_db;
  logic                   start_db_prev;
  logic [DB_W-1:0]        db_cnt;
  logic                   launch;
  logic                   abort;
  logic                   halt;

  run_state_t             state;
  logic [RST_W-1:0]       rst_cnt;
  logic [31:0]            cycle_cnt;

  assign start_s = sync_q[SYNC_STAGES-1];
  assign launch  = start_db & ~start_db_prev;
  assign abort   = ~start_db & start_db_prev;
  assign halt    = cpu_we && (cpu_ab == HALT_ADDR);

  // Bring the raw switch into the clk domain
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], start};
  end

  // Accept a new start level only after it has differed for DEBOUNCE_CYCLES consecutive cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      start_db      <= 1'b0;
      start_db_prev <= 1'b0;
      db_cnt        <= '0;
    end else begin
      start_db_prev <= start_db;
      if (start_s != start_db) begin
        if (db_cnt == DB_LAST) begin
          start_db <= start_s;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Run FSM; outputs are set together with the state they belong to, so they are registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      rst_cnt   <= '0;
      cycle_cnt <= '0;
      cpu_reset <= 1'b1;
      cpu_rdy   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      disp_val  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch) begin
            state     <= ST_RST;
            rst_cnt   <= RST_CNT_LOAD;
            cycle_cnt <= '0;
            busy      <= 1'b1;
          end
        end
        ST_RST: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (rst_cnt == '0) begin
            state     <= ST_RUN;
            cpu_reset <= 1'b0;
            cpu_rdy   <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end
        ST_RUN: begin
          // Saturate rather than wrap so a huge budget never aliases back to zero
          if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
          // Halt beats timeout beats abort when they land in the same cycle
          if (halt) begin
            state     <= ST_DONE;
            disp_val  <= {cpu_do, cycle_cnt[23:0]};
            cpu_reset <= 1'b1;
            cpu_rdy   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (cycle_cnt == TIMEOUT_AT) begin
            state     <= ST_TIMEOUT;
            disp_val  <= {16'hDEAD, cycle_cnt[15:0]};
            cpu_reset <= 1'b1;
            cpu_rdy   <= 1'b0;
            busy      <= 1'b0;
            timeout   <= 1'b1;
          end else if (abort) begin
            state     <= ST_IDLE;
            cpu_reset <= 1'b1;
            cpu_rdy   <= 1'b0;
            busy      <= 1'b0;
          end
        end
        ST_DONE, ST_TIMEOUT: begin
          // Result is held until the operator relaunches; switching off is not an abort here
          if (launch) begin
            state     <= ST_RST;
            rst_cnt   <= RST_CNT_LOAD;
            cycle_cnt <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cpu_reset <= 1'b1;
          cpu_rdy   <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          timeout   <= 1'b0;
        end
      endcase
    end
  end

`ifdef CPU_RUN_SEG_DECODE_EN
  logic [7:0][6:0] seg_dec;
  logic [7:0][6:0] seg_q;

  for (genvar gi = 0; gi < 8; gi++) begin : g_dec
    hex7seg u_hex7seg (
      .nib (disp_val[gi*4 +: 4]),
      .seg (seg_dec[gi])
    );
  end

  // Register decoded digits so the segment pins stay glitch-free
  always_ff @(posedge clk) begin
    if (reset) seg_q <= {8{SEG_ZERO}};
    else       seg_q <= seg_dec;
  end

  assign seg0 = seg_q[0];
  assign seg1 = seg_q[1];
  assign seg2 = seg_q[2];
  assign seg3 = seg_q[3];
  assign seg4 = seg_q[4];
  assign seg5 = seg_q[5];
  assign seg6 = seg_q[6];
  assign seg7 = seg_q[7];
`else
  assign seg0 = SEG_OFF;
  assign seg1 = SEG_OFF;
  assign seg2 = SEG_OFF;
  assign seg3 = SEG_OFF;
  assign seg4 = SEG_OFF;
  assign seg5 = SEG_OFF;
  assign seg6 = SEG_OFF;
  assign seg7 = SEG_OFF;
`endif

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Self-checking bench for cpu_run_sequencer: vector table, hand sequences and random runs vs a run-outcome model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cpu_run_sequencer;

  localparam int          DEB       = 4;
  localparam int          RSTC      = 8;
  localparam int          MAXC      = 200;
  localparam int          SYNC      = 2;
  localparam logic [15:0] HALT      = 16'hFFF0;
  // Start pin change to the FSM acting on it: sync flops plus debounce window
  localparam int          ABORT_LAT = SYNC + DEB;
  localparam int          NONE      = 1000000;

  localparam int K_IDLE = 0;
  localparam int K_DONE = 1;
  localparam int K_TMO  = 2;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] cpu_ab;
  logic        cpu_we;
  logic [7:0]  cpu_do;
  logic        cpu_reset;
  logic        cpu_rdy;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] disp_val;
  logic [6:0]  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;

  int tests  = 0;
  int failed = 0;
  logic [31:0] prev_disp;

  cpu_run_sequencer #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .RST_CYCLES      (RSTC),
    .HALT_ADDR       (HALT),
    .MAX_CYCLES      (32'(MAXC))
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cpu_ab    (cpu_ab),
    .cpu_we    (cpu_we),
    .cpu_do    (cpu_do),
    .cpu_reset (cpu_reset),
    .cpu_rdy   (cpu_rdy),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .disp_val  (disp_val),
    .seg0      (seg0),
    .seg1      (seg1),
    .seg2      (seg2),
    .seg3      (seg3),
    .seg4      (seg4),
    .seg5      (seg5),
    .seg6      (seg6),
    .seg7      (seg7)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          h;
    int          a;
    logic [7:0]  d;
    int          kind;
    int          end_c;
    logic [31:0] disp;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    failed++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Outcome of one run from the rules: first of halt, budget end, effective abort wins, in that priority
  function automatic void model(input int h, input int a, input logic [7:0] d, input logic [31:0] prev,
                                output int kind, output int end_c, output logic [31:0] disp);
    int hh;
    int ae;
    int tl;
    hh = (h < 0) ? NONE : h;
    ae = (a < 0) ? NONE : a + ABORT_LAT;
    tl = MAXC - 1;
    if (hh <= tl && hh <= ae) begin
      kind = K_DONE; end_c = hh; disp = {d, 24'(hh)};
    end else if (tl <= ae) begin
      kind = K_TMO;  end_c = tl; disp = {16'hDEAD, 16'(tl)};
    end else begin
      kind = K_IDLE; end_c = ae; disp = prev;
    end
  endfunction

  task automatic decoy_bus();
    cpu_we = 1'($urandom);
    cpu_ab = 16'($urandom);
    if (cpu_ab == HALT) cpu_ab = cpu_ab ^ 16'h0001;
    cpu_do = 8'($urandom);
  endtask

  task automatic run_case(input string tag, input int h, input int a, input logic [7:0] d,
                          input int exp_kind, input int exp_end, input logic [31:0] exp_disp);
    int cnt;
    int n;
    bit got;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    // Halt writes before RUN must be ignored
    cpu_we = 1'b1; cpu_ab = HALT; cpu_do = 8'hEE;
    start = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (busy) got = 1;
    end
    if (!got) begin bound_fail({tag, " launch"}); return; end
    cnt = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      cnt++;
      if (cpu_rdy) got = 1;
    end
    if (!got) begin bound_fail({tag, " release"}); return; end
    chk({tag, " rst_len"}, cnt, RSTC);
    chk({tag, " cpu_reset_run"}, cpu_reset, 1'b0);
    n = 0; got = 0;
    while (!got && n < MAXC + 30) begin
      if (n == h) begin
        cpu_we = 1'b1; cpu_ab = HALT; cpu_do = d;
      end else begin
        decoy_bus();
      end
      if (n == a) start = 1'b0;
      @(posedge clk); #1;
      if (cpu_rdy) n++;
      else got = 1;
    end
    cpu_we = 1'b0;
    if (!got) begin bound_fail({tag, " run_end"}); return; end
    chk({tag, " end_cycle"}, n, exp_end);
    chk({tag, " done"}, done, exp_kind == K_DONE);
    chk({tag, " timeout"}, timeout, exp_kind == K_TMO);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " cpu_reset"}, cpu_reset, 1'b1);
    chk({tag, " disp_val"}, disp_val, exp_disp);
    if (exp_kind == K_IDLE) begin
      repeat (200) @(posedge clk);
      #1;
      chk({tag, " idle_busy"}, busy, 1'b0);
      chk({tag, " idle_disp"}, disp_val, exp_disp);
    end else begin
      // Switching off after a finished run leaves the status in place
      start = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      chk({tag, " held_done"}, done, exp_kind == K_DONE);
      chk({tag, " held_tmo"}, timeout, exp_kind == K_TMO);
    end
  endtask

  initial begin
    logic [6:0] exp_seg;
    int k, e;
    logic [31:0] dv;
    int h, a;
    logic [7:0] d;

`ifdef CPU_RUN_SEG_DECODE_EN
    exp_seg = 7'h12;
`else
    exp_seg = 7'h7F;
`endif

    tbl[0] = '{h: 37,  a: -1, d: 8'h5A, kind: K_DONE, end_c: 37,  disp: 32'h5A000025};
    tbl[1] = '{h: -1,  a: -1, d: 8'h00, kind: K_TMO,  end_c: 199, disp: 32'hDEAD00C7};
    tbl[2] = '{h: -1,  a: 10, d: 8'h00, kind: K_IDLE, end_c: 16,  disp: 32'hDEAD00C7};
    tbl[3] = '{h: 199, a: -1, d: 8'hC3, kind: K_DONE, end_c: 199, disp: 32'hC30000C7};
    tbl[4] = '{h: 16,  a: 10, d: 8'h77, kind: K_DONE, end_c: 16,  disp: 32'h77000010};
    tbl[5] = '{h: 0,   a: -1, d: 8'hA5, kind: K_DONE, end_c: 0,   disp: 32'hA5000000};
    tbl[6] = '{h: 20,  a: -1, d: 8'h11, kind: K_DONE, end_c: 20,  disp: 32'h11000014};

    reset = 1'b1; start = 1'b0; cpu_we = 1'b0; cpu_ab = 16'h0000; cpu_do = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("rst cpu_reset", cpu_reset, 1'b1);
    chk("rst cpu_rdy", cpu_rdy, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst timeout", timeout, 1'b0);
    chk("rst disp_val", disp_val, 32'h0);
`ifdef CPU_RUN_SEG_DECODE_EN
    chk("rst seg0", seg0, 7'h40);
`else
    chk("rst seg0", seg0, 7'h7F);
`endif
    prev_disp = 32'h0;

    for (int i = 0; i < 7; i++) begin
      run_case($sformatf("tbl%0d", i), tbl[i].h, tbl[i].a, tbl[i].d, tbl[i].kind, tbl[i].end_c, tbl[i].disp);
      prev_disp = tbl[i].disp;
      if (i == 0) begin
        chk("seg0 digit5", seg0, exp_seg);
        chk("seg7 digit5", seg7, exp_seg);
      end
    end

    // Short start pulses must not launch
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    for (int w = 1; w <= 3; w++) begin
      int seen;
      seen = 0;
      start = 1'b1;
      repeat (w) @(posedge clk);
      #1 start = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        if (busy || !cpu_reset) seen++;
      end
      chk($sformatf("glitch%0d", w), seen, 0);
    end

    for (int r = 0; r < 20; r++) begin
      h = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 230));
      a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 210)) : -1;
      d = 8'($urandom);
      model(h, a, d, prev_disp, k, e, dv);
      run_case($sformatf("rnd%0d h=%0d a=%0d", r, h, a), h, a, d, k, e, dv);
      prev_disp = dv;
    end

    // Synchronous reset in the middle of a run
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1 start = 1'b1;
    begin
      bit got;
      got = 0;
      for (int i = 0; i < 80 && !got; i++) begin
        @(posedge clk); #1;
        if (cpu_rdy) got = 1;
      end
      if (!got) bound_fail("midrst run");
    end
    repeat (30) @(posedge clk);
    #1;
    chk("midrst running", cpu_rdy, 1'b1);
    reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst cpu_reset", cpu_reset, 1'b1);
    chk("midrst cpu_rdy", cpu_rdy, 1'b0);
    chk("midrst busy", busy, 1'b0);
    chk("midrst disp_val", disp_val, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
